tree_acc_ctrl: RTL and testbench

TREE_ACC_CTRL -- requirements
Module: tree_acc_ctrl

---
 rtl/tree_acc_ctrl_if.sv | 27 ++
 rtl/tree_acc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_tree_acc_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tree_acc_ctrl_if.sv
// Bundle of job, operand-memory and result handshake signals for tree_acc_ctrl.
// master: the job issuer / memory side; slave: the accumulator controller.
interface tree_acc_ctrl_if #(
    parameter int GROUP_W = 3
);
    logic               start;
    logic [GROUP_W-1:0] last_group;
    logic [20:0]        bias;
    logic [GROUP_W-1:0] grp_addr;
    logic               mem_rd;
    logic [20:0]        tree_res;
    logic [23:0]        acc_out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               sat;

    modport master (
        output start, last_group, bias, tree_res, out_ready,
        input  grp_addr, mem_rd, acc_out, out_valid, busy, sat
    );

    modport slave (
        input  start, last_group, bias, tree_res, out_ready,
        output grp_addr, mem_rd, acc_out, out_valid, busy, sat
    );
endinterface

// File: rtl/tree_acc_ctrl.sv
// Accumulator controller: walks groups 0..last_group of the operand memory,
// folds each sign-magnitude adder-tree sum into a saturating 24-bit
// sign-magnitude accumulator, and holds the result until it is accepted.
module tree_acc_ctrl #(
    parameter int GROUP_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    tree_acc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GROUP_W-1:0] r_grp_addr;
    logic [GROUP_W-1:0] w_grp_addr_nxt;
    logic [GROUP_W-1:0] r_last_group;
    logic               r_mem_rd;
    logic               w_mem_rd_nxt;
    logic               r_rd_pending;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic               w_load;
    logic               r_sat;
    logic [23:0]        r_acc;
    logic [23:0]        w_bias_ext;
    logic [24:0]        w_step;

    // Sign-magnitude add of the 24-bit accumulator and a 21-bit tree sum.
    // Returns {overflow, sign, magnitude}; -0 inputs are read as +0, a zero
    // result is always +0, and overflowing magnitudes clamp to full scale.
    function automatic logic [24:0] sm_add(input logic [23:0] a, input logic [20:0] b);
        logic        sa;
        logic        sb;
        logic        sr;
        logic        ov;
        logic [22:0] ma;
        logic [22:0] mb;
        logic [22:0] mr;
        logic [23:0] sum;
        ma  = a[22:0];
        mb  = {3'b000, b[19:0]};
        sa  = a[23] & (|ma);
        sb  = b[20] & (|mb);
        ov  = 1'b0;
        sum = {1'b0, ma} + {1'b0, mb};
        if (sa == sb) begin
            sr = sa;
            if (sum[23]) begin
                mr = 23'h7FFFFF;
                ov = 1'b1;
            end else begin
                mr = sum[22:0];
            end
        end else if (ma >= mb) begin
            mr = ma - mb;
            sr = sa;
        end else begin
            mr = mb - ma;
            sr = sb;
        end
        sr = sr & (|mr);
        return {ov, sr, mr};
    endfunction

    // Bias widened to accumulator format; a -0 bias is loaded as +0.
    assign w_bias_ext = {bus.bias[20] & (|bus.bias[19:0]), 3'b000, bus.bias[19:0]};
    assign w_step     = sm_add(r_acc, bus.tree_res);

    assign bus.grp_addr  = r_grp_addr;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.acc_out   = r_acc;
    assign bus.out_valid = r_out_valid;
    assign bus.sat       = r_sat;
    assign bus.busy      = (r_state != ST_IDLE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; group reads issue back to back.
    always_comb begin
        w_state_nxt     = r_state;
        w_grp_addr_nxt  = r_grp_addr;
        w_mem_rd_nxt    = 1'b0;
        w_out_valid_nxt = r_out_valid;
        w_load          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt    = ST_ISSUE;
                    w_grp_addr_nxt = {GROUP_W{1'b0}};
                    w_mem_rd_nxt   = 1'b1;
                    w_load         = 1'b1;
                end else begin
                    w_mem_rd_nxt = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (r_grp_addr == r_last_group) begin
                    w_state_nxt  = ST_DRAIN;
                    w_mem_rd_nxt = 1'b0;
                end else begin
                    w_grp_addr_nxt = r_grp_addr + GROUP_W'(1);
                    w_mem_rd_nxt   = 1'b1;
                end
            end
            ST_DRAIN: begin
                // last tree sum lands on this edge, so the result is final
                w_state_nxt     = ST_OUT;
                w_out_valid_nxt = 1'b1;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_out_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Control registers: read strobe, address, read-pending pipe, result valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grp_addr   <= {GROUP_W{1'b0}};
            r_last_group <= {GROUP_W{1'b0}};
            r_mem_rd     <= 1'b0;
            r_rd_pending <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_grp_addr   <= w_grp_addr_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
            r_rd_pending <= r_mem_rd;
            r_out_valid  <= w_out_valid_nxt;
            if (w_load) begin
                r_last_group <= bus.last_group;
            end else begin
                r_last_group <= r_last_group;
            end
        end
    end

    // Accumulator and sticky saturation: load bias on start, add each tree sum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= 24'h000000;
            r_sat <= 1'b0;
        end else if (w_load) begin
            r_acc <= w_bias_ext;
            r_sat <= 1'b0;
        end else if (r_rd_pending) begin
            r_acc <= w_step[23:0];
            r_sat <= r_sat | w_step[24];
        end else begin
            r_acc <= r_acc;
            r_sat <= r_sat;
        end
    end
endmodule

// File: tb/tb_tree_acc_ctrl.sv
// Directed self-checking bench for tree_acc_ctrl.
module tb_tree_acc_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    tree_acc_ctrl_if #(.GROUP_W(3)) bus ();

    tree_acc_ctrl #(.GROUP_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one job and observe it until out_valid; answers reads one cycle late.
    task automatic run_job(input logic [2:0] lg, input logic [20:0] b, input logic [20:0] v [8],
                           output int lat, output int rd_cnt, output bit seq_ok);
        bit         prev_rd;
        logic [2:0] prev_addr;
        bus.start = 1'b1; bus.last_group = lg; bus.bias = b;
        tick();
        bus.start = 1'b0; bus.last_group = ~lg; bus.bias = 21'h155555;
        lat = -1; rd_cnt = 0; seq_ok = 1'b1; prev_rd = 1'b0; prev_addr = 3'd0;
        for (int k = 0; k < 40; k++) begin
            bus.tree_res = prev_rd ? v[prev_addr] : 21'h0ABCDE;
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
            prev_rd = (bus.mem_rd === 1'b1);
            prev_addr = bus.grp_addr;
            if (prev_rd) begin
                if (bus.grp_addr !== rd_cnt[2:0] || k != rd_cnt) seq_ok = 1'b0;
                rd_cnt++;
            end
            tick();
        end
        bus.tree_res = 21'h0ABCDE;
    endtask

    task automatic test_reset;
        rst = 1'b0; bus.start = 1'b1;
        tick(); tick();
        n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got %b exp 0", bus.mem_rd); end
        n_checks++; if (bus.grp_addr !== 3'd0) begin n_fail++; $display("FAIL reset_grp_addr got %0d exp 0", bus.grp_addr); end
        n_checks++; if (bus.acc_out !== 24'h000000) begin n_fail++; $display("FAIL reset_acc got %h exp 000000", bus.acc_out); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b exp 0", bus.sat); end
        bus.start = 1'b0; rst = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [20:0] v [8];
        int lat; int rd; bit ok;
        foreach (v[i]) v[i] = 21'h000000;
        v[0] = 21'd100;
        run_job(3'd0, 21'h000000, v, lat, rd, ok);
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL single_latency got %0d exp 2", lat); end
        n_checks++; if (rd != 1 || !ok) begin n_fail++; $display("FAIL single_reads got %0d ok=%b exp 1 ok=1", rd, ok); end
        n_checks++; if (bus.acc_out !== 24'h000064) begin n_fail++; $display("FAIL single_acc got %h exp 000064", bus.acc_out); end
        n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL single_sat got %b exp 0", bus.sat); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", bus.busy); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_accept valid=%b busy=%b exp 0 0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_mixed_signs;
        logic [20:0] v [8];
        int lat; int rd; bit ok;
        foreach (v[i]) v[i] = 21'h000000;
        v[0] = 21'd5; v[1] = 21'h100014; v[2] = 21'd3; v[3] = 21'h100001;
        run_job(3'd3, 21'd10, v, lat, rd, ok);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL mixed_latency got %0d exp 5", lat); end
        n_checks++; if (rd != 4 || !ok) begin n_fail++; $display("FAIL mixed_reads got %0d ok=%b exp 4 ok=1", rd, ok); end
        n_checks++; if (bus.acc_out !== 24'h800003) begin n_fail++; $display("FAIL mixed_acc got %h exp 800003", bus.acc_out); end
        n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL mixed_sat got %b exp 0", bus.sat); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        // +3 plus -(2^20-1): tree sum dominates, result negative
        foreach (v[i]) v[i] = 21'h000000;
        v[0] = 21'h1FFFFF;
        run_job(3'd0, 21'd3, v, lat, rd, ok);
        n_checks++; if (bus.acc_out !== 24'h8FFFFC) begin n_fail++; $display("FAIL flip_acc got %h exp 8ffffc", bus.acc_out); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    endtask

    task automatic test_saturate;
        logic [20:0] v [8];
        int lat; int rd; bit ok;
        foreach (v[i]) v[i] = 21'h0FFFFF;
        run_job(3'd7, 21'h0FFFFF, v, lat, rd, ok);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL sat_latency got %0d exp 9", lat); end
        n_checks++; if (rd != 8 || !ok) begin n_fail++; $display("FAIL sat_reads got %0d ok=%b exp 8 ok=1", rd, ok); end
        n_checks++; if (bus.acc_out !== 24'h7FFFFF) begin n_fail++; $display("FAIL sat_acc got %h exp 7fffff", bus.acc_out); end
        n_checks++; if (bus.sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b exp 1", bus.sat); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    endtask

    task automatic test_zero_sign;
        logic [20:0] v [8];
        int lat; int rd; bit ok;
        foreach (v[i]) v[i] = 21'h000000;
        v[0] = 21'h100007;
        run_job(3'd0, 21'd7, v, lat, rd, ok);
        n_checks++; if (bus.acc_out !== 24'h000000) begin n_fail++; $display("FAIL cancel_acc got %h exp 000000", bus.acc_out); end
        n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL cancel_sat_cleared got %b exp 0", bus.sat); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        v[0] = 21'h100000;
        run_job(3'd0, 21'h100000, v, lat, rd, ok);
        n_checks++; if (bus.acc_out !== 24'h000000) begin n_fail++; $display("FAIL negzero_acc got %h exp 000000", bus.acc_out); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    endtask

    task automatic test_back_pressure;
        logic [20:0] v [8];
        int lat; int rd; bit ok;
        foreach (v[i]) v[i] = 21'h000000;
        v[0] = 21'd1; v[1] = 21'd2;
        run_job(3'd1, 21'h000000, v, lat, rd, ok);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL bp_latency got %0d exp 3", lat); end
        bus.out_ready = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.acc_out !== 24'h000003 || bus.mem_rd !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d valid=%b acc=%h rd=%b busy=%b exp 1 000003 0 1",
                         i, bus.out_valid, bus.acc_out, bus.mem_rd, bus.busy);
            end
        end
        bus.start = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_release valid=%b busy=%b exp 0 0", bus.out_valid, bus.busy); end
        tick();
        n_checks++; if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_restart rd=%b busy=%b exp 0 0", bus.mem_rd, bus.busy); end
    endtask

    task automatic test_abort;
        logic [20:0] v [8];
        int lat; int rd; bit ok; bit hit;
        bus.start = 1'b1; bus.last_group = 3'd5; bus.bias = 21'd80; bus.tree_res = 21'd9;
        tick();
        bus.start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.grp_addr === 3'd2 && bus.mem_rd === 1'b1) begin hit = 1'b1; break; end
            tick();
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL abort_reach_grp2 got grp=%0d exp 2", bus.grp_addr); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.mem_rd !== 1'b0 || bus.grp_addr !== 3'd0 || bus.acc_out !== 24'h000000 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sat !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs rd=%b grp=%0d acc=%h valid=%b busy=%b sat=%b exp all 0",
                     bus.mem_rd, bus.grp_addr, bus.acc_out, bus.out_valid, bus.busy, bus.sat);
        end
        rst = 1'b1;
        tick();
        foreach (v[i]) v[i] = 21'h000000;
        v[0] = 21'd1; v[1] = 21'd1;
        run_job(3'd1, 21'h000000, v, lat, rd, ok);
        n_checks++; if (lat != 3 || rd != 2 || !ok) begin n_fail++; $display("FAIL abort_rejob lat=%0d rd=%0d ok=%b exp 3 2 1", lat, rd, ok); end
        n_checks++; if (bus.acc_out !== 24'h000002) begin n_fail++; $display("FAIL abort_rejob_acc got %h exp 000002", bus.acc_out); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.last_group = 3'd0; bus.bias = 21'h000000;
        bus.tree_res = 21'h000000; bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_mixed_signs();
        test_saturate();
        test_zero_sign();
        test_back_pressure();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
